// File: rtl/divider_pkg.sv
// Shared types for the restoring divider.
package divider_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/divider_if.sv
// Level start/ready handshake bus between a divide requester and the divider.
interface divider_if #(parameter int N = 4);
    logic           start;
    logic [2*N-1:0] Din;
    logic [N-1:0]   Min;
    logic [N-1:0]   Q;
    logic [N-1:0]   R;
    logic           ready;
    logic           error;

    modport master (output start, Din, Min, input Q, R, ready, error);
    modport slave  (input start, Din, Min, output Q, R, ready, error);
endinterface

// File: rtl/divider.sv
// Restoring 2N/N unsigned divider, one quotient bit per clock; ready N+1 edges after accept, 1 edge on error.
// Result held in DONE while start stays high; outputs keep their values until the next accept.
import divider_pkg::*;

module divider #(
    parameter int N = 4
) (
    input  logic     clock,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    state_t         state;
    logic [N:0]     a;
    logic [N-1:0]   q;
    logic [N-1:0]   m;
    logic [N-1:0]   r;
    logic [CW-1:0]  count;
    logic           ready;
    logic           error;

    logic [N:0]     a_sh;
    logic [N+1:0]   diff;
    logic           neg;
    logic [N:0]     a_next;

    // A never exceeds M-1 between steps, so its top bit is always zero before the shift.
    always_comb begin
        a_sh   = {a[N-1:0], q[N-1]};
        diff   = {1'b0, a_sh} - {2'b00, m};
        neg    = diff[N+1];
        a_next = neg ? a_sh : diff[N:0];
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            r     <= '0;
            count <= '0;
            ready <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Zero divisor or high half >= divisor: quotient would not fit in N bits.
                        if (bus.Min == '0 || bus.Din[2*N-1:N] >= bus.Min) begin
                            q     <= '1;
                            r     <= '0;
                            error <= 1'b1;
                            ready <= 1'b1;
                            state <= DONE;
                        end else begin
                            a     <= {1'b0, bus.Din[2*N-1:N]};
                            q     <= bus.Din[N-1:0];
                            m     <= bus.Min;
                            count <= CW'(N);
                            error <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    a     <= a_next;
                    q     <= {q[N-2:0], ~neg};
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        r     <= a_next[N-1:0];
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Q     = q;
    assign bus.R     = r;
    assign bus.ready = ready;
    assign bus.error = error;
endmodule
